reset_sequencer: RTL and testbench

Parametrised single-clock reset sequencer that generates `NUM_DOM` active-low domain resets from one asynchronous external reset and a synchronous software reset request. It is the successor to the fixed two-flop `corerstn` synchroniser in the system top. It synchronises the external request, stretches it to a minimum hold time, and releases the domains in index order with a fixed stagger. All domains are re-asserted together on any new request.

---
 rtl/reset_pkg.sv | 29 ++
 rtl/reset_sequencer_sync_chain.sv | 34 +++
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// ---------------------------------------------------------------------------
// reset_pkg
// Shared definitions for the reset sequencer: FSM state encoding, default
// timing constants and a small helper used to size the timing counter.
// ---------------------------------------------------------------------------
package reset_pkg;

    // HOLD : all domains in reset, waiting for a quiet period
    // STEP : domains being released one at a time
    // RUN  : every domain released
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } rstseq_state_t;

    localparam int RSTSEQ_SYNC_STAGES_DEF = 2;
    localparam int RSTSEQ_HOLD_DEF        = 16;
    localparam int RSTSEQ_STEP_DEF        = 8;
    localparam int RSTSEQ_NUM_DOM_DEF     = 3;

    // Saturation value of the optional request counter.
    localparam logic [7:0] RSTSEQ_COUNT_MAX = 8'hFF;

    function automatic int rstseq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Single-bit multi-flop synchroniser. All stages reset to 0, so a freshly
// reset chain reports "external reset active" until the input has been
// sampled high STAGES times.
//
// Ports:
//   clock  in  1  sampling clock
//   reset  in  1  synchronous active-high reset, clears every stage
//   d      in  1  asynchronous input
//   q      out 1  synchronised output (last stage)
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Generates NUM_DOM active-low domain resets from an asynchronous external
// reset and a synchronous software request. The external reset is
// synchronised, any request is stretched to at least HOLD_CYCLES quiet
// cycles, then domains are released in index order every STEP_CYCLES cycles.
// Any new request re-asserts every domain at once.
//
// Optional feature macro: RSTSEQ_COUNT_EN adds rst_count, a saturating count
// of sequences aborted by a request after at least domain 0 was released.
//
// Ports:
//   clock         in  1        single clock, rising edge
//   reset         in  1        synchronous active-high block reset
//   ext_rstn      in  1        external reset, active low, asynchronous
//   sw_rst_req    in  1        software reset request, active high
//   dom_rstn      out NUM_DOM  per-domain reset, active low, registered
//   busy          out 1        high whenever not in RUN
//   all_released  out 1        high only in RUN
//   rst_count     out 8        (RSTSEQ_COUNT_EN only) request counter
// ---------------------------------------------------------------------------
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_DOM     = RSTSEQ_NUM_DOM_DEF,
    parameter int SYNC_STAGES = RSTSEQ_SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = RSTSEQ_HOLD_DEF,
    parameter int STEP_CYCLES = RSTSEQ_STEP_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ext_rstn,
    input  logic               sw_rst_req,
    output logic [NUM_DOM-1:0] dom_rstn,
    output logic               busy,
    output logic               all_released
`ifdef RSTSEQ_COUNT_EN
    ,
    output logic [7:0]         rst_count
`endif
);

    localparam int CNT_W = $clog2(rstseq_max(HOLD_CYCLES, STEP_CYCLES)) + 1;
    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    rstseq_state_t      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               busy_q, all_rel_q;

    logic ext_sync;
    logic req;
    int   nxt_idx;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (ext_rstn),
        .q     (ext_sync)
    );

    // A low synchronised external reset and a software request are treated
    // identically.
    assign req = ~ext_sync | sw_rst_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        nxt_idx = int'(idx_q) + 1;

        case (state_q)
            HOLD: begin
                dom_d = '0;
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    dom_d[0] = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = (NUM_DOM == 1) ? RUN : STEP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STEP: begin
                if (req) begin
                    // Request wins over a coincident release edge.
                    dom_d   = '0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (cnt_q == STEP_LAST) begin
                    // Index compared as int so the code elaborates even when
                    // NUM_DOM==1 and this branch is unreachable.
                    for (int i = 0; i < NUM_DOM; i++) begin
                        if (i == nxt_idx) begin
                            dom_d[i] = 1'b1;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                    if (nxt_idx == NUM_DOM - 1) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RUN: begin
                if (req) begin
                    dom_d   = '0;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end

            default: begin
                dom_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            dom_q     <= '0;
            busy_q    <= 1'b1;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            dom_q     <= dom_d;
            // Registered from the next state so the flags move on the same
            // edge as the last release or the first re-assertion.
            busy_q    <= (state_d != RUN);
            all_rel_q <= (state_d == RUN);
        end
    end

    assign dom_rstn     = dom_q;
    assign busy         = busy_q;
    assign all_released = all_rel_q;

`ifdef RSTSEQ_COUNT_EN
    logic [7:0] count_q;
    logic       abort_evt;

    // Only requests that pull a released (STEP/RUN) sequence back to HOLD
    // are counted; requests while already holding are not.
    assign abort_evt = req && (state_q != HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (abort_evt && (count_q != RSTSEQ_COUNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign rst_count = count_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Drives two sequencers (default parameters, and a single-domain instance
// with HOLD_CYCLES=1) from the same inputs and checks them every cycle
// against a model expressed as "edges since the last request".
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int N0  = 3;
    localparam int S0  = 2;
    localparam int H0  = 16;
    localparam int ST0 = 8;
    localparam int N1  = 1;
    localparam int H1  = 1;
    localparam int ST1 = 1;

    logic          clock;
    logic          reset;
    logic          ext_rstn;
    logic          sw_rst_req;
    logic [N0-1:0] dom_rstn;
    logic          busy;
    logic          all_released;
    logic [N1-1:0] dom1_rstn;
    logic          busy1;
    logic          all1_released;
`ifdef RSTSEQ_COUNT_EN
    logic [7:0]    rst_count;
    logic [7:0]    rst_count1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    logic [S0-1:0] hist;      // external reset samples, [0] newest
    int            quiet;     // consecutive edges with no request
    int            cnt_m0;
    int            cnt_m1;

    reset_sequencer #(
        .NUM_DOM(N0), .SYNC_STAGES(S0), .HOLD_CYCLES(H0), .STEP_CYCLES(ST0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ext_rstn     (ext_rstn),
        .sw_rst_req   (sw_rst_req),
        .dom_rstn     (dom_rstn),
        .busy         (busy),
        .all_released (all_released)
`ifdef RSTSEQ_COUNT_EN
        ,
        .rst_count    (rst_count)
`endif
    );

    reset_sequencer #(
        .NUM_DOM(N1), .SYNC_STAGES(S0), .HOLD_CYCLES(H1), .STEP_CYCLES(ST1)
    ) dut1 (
        .clock        (clock),
        .reset        (reset),
        .ext_rstn     (ext_rstn),
        .sw_rst_req   (sw_rst_req),
        .dom_rstn     (dom1_rstn),
        .busy         (busy1),
        .all_released (all1_released)
`ifdef RSTSEQ_COUNT_EN
        ,
        .rst_count    (rst_count1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
            end
        end
    endtask

    // Model: domain i is out of reset once the quiet run reaches
    // HOLD + i*STEP edges; any request restarts the quiet run.
    task automatic model_edge(input logic r, input logic e, input logic sw);
        logic rq;
        if (r) begin
            hist   = '0;
            quiet  = 0;
            cnt_m0 = 0;
            cnt_m1 = 0;
        end else begin
            rq = !hist[S0-1] || sw;
            if (rq) begin
                if (quiet >= H0 && cnt_m0 < 255) cnt_m0++;
                if (quiet >= H1 && cnt_m1 < 255) cnt_m1++;
                quiet = 0;
            end else if (quiet < 1000000) begin
                quiet++;
            end
            hist = {hist[S0-2:0], e};
        end
    endtask

    task automatic check_outputs();
        logic [N0-1:0] ed;
        logic [N1-1:0] ed1;
        for (int i = 0; i < N0; i++) ed[i] = (quiet >= H0 + i * ST0);
        for (int i = 0; i < N1; i++) ed1[i] = (quiet >= H1 + i * ST1);
        check_eq("dom",    32'(dom_rstn),      32'(ed));
        check_eq("busy",   32'(busy),          32'(!(quiet >= H0 + (N0 - 1) * ST0)));
        check_eq("allrel", 32'(all_released),  32'(quiet >= H0 + (N0 - 1) * ST0));
        check_eq("dom1",   32'(dom1_rstn),     32'(ed1));
        check_eq("busy1",  32'(busy1),         32'(!(quiet >= H1 + (N1 - 1) * ST1)));
        check_eq("allrel1",32'(all1_released), 32'(quiet >= H1 + (N1 - 1) * ST1));
`ifdef RSTSEQ_COUNT_EN
        check_eq("count",  32'(rst_count),  32'(cnt_m0));
        check_eq("count1", 32'(rst_count1), 32'(cnt_m1));
`endif
    endtask

    // One clock: inputs are already set; update model at the edge, check
    // outputs at the following falling edge.
    task automatic step();
        logic r, e, sw;
        r  = reset;
        e  = ext_rstn;
        sw = sw_rst_req;
        @(posedge clock);
        model_edge(r, e, sw);
        cyc++;
        @(negedge clock);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        hist       = '0;
        quiet      = 0;
        cnt_m0     = 0;
        cnt_m1     = 0;
        reset      = 1'b1;
        ext_rstn   = 1'b1;
        sw_rst_req = 1'b0;

        // 1: power-up
        run(4);
        check_eq("rst_dom",  32'(dom_rstn), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(1));
        reset = 1'b0;
        n = 0;
        while (dom_rstn[0] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        // First edge after reset is E; release after E+S+H-1
        check_eq("pwrup_lat", 32'(n), 32'(S0 + H0));
        run(2 * ST0 + 4);
        check_eq("pwrup_all", 32'(dom_rstn), 32'(3'b111));
        $display("power-up sequence done at cycle %0d", cyc);

        // 2: one-cycle software pulse in RUN
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check_eq("sw_assert", 32'(dom_rstn), 32'(0));
        run(H0 + 2 * ST0 + 4);
        $display("software pulse re-sequence done at cycle %0d", cyc);

        // 3: one-cycle external reset glitch
        ext_rstn = 1'b0;
        step();
        ext_rstn = 1'b1;
        run(2);
        check_eq("ext_assert", 32'(dom_rstn), 32'(0));
        run(H0 + 2 * ST0 + 4);
        $display("external glitch re-sequence done at cycle %0d", cyc);

        // 4: request while dom_rstn=011, then request on the 011->111 edge
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        n = 0;
        while (quiet != H0 + ST0 + 3 && n < 200) begin
            step();
            n++;
        end
        check_eq("s4_mid", 32'(dom_rstn), 32'(3'b011));
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check_eq("s4_abort", 32'(dom_rstn), 32'(0));
        n = 0;
        while (quiet != H0 + 2 * ST0 - 1 && n < 200) begin
            step();
            n++;
        end
        check_eq("s4_edge_pre", 32'(dom_rstn), 32'(3'b011));
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check_eq("s4_edge", 32'(dom_rstn), 32'(0));
        run(H0 + 2 * ST0 + 4);
        $display("mid-step abort checks done at cycle %0d", cyc);

        // 6: 300 pulses spaced 40 cycles apart, then reset
        for (int p = 0; p < 300; p++) begin
            sw_rst_req = 1'b1;
            step();
            sw_rst_req = 1'b0;
            run(39);
        end
`ifdef RSTSEQ_COUNT_EN
        check_eq("count_sat", 32'(rst_count), 32'(255));
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef RSTSEQ_COUNT_EN
        check_eq("count_clr", 32'(rst_count), 32'(0));
`endif
        check_eq("rst_again", 32'(dom_rstn), 32'(0));
        $display("pulse train done at cycle %0d", cyc);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 499) == 0);
            ext_rstn   = ($urandom_range(0, 59) != 0);
            sw_rst_req = ($urandom_range(0, 44) == 0);
            step();
            if ($urandom_range(0, 3) == 0) begin
                reset      = 1'b0;
                ext_rstn   = 1'b1;
                sw_rst_req = 1'b0;
                run($urandom_range(1, 40));
            end
        end
        $display("random traffic done at cycle %0d", cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
